// File: rtl/d_latch_pkg.sv
// Shared constants and mode encoding for the clocked D-latch emulation.
// The top maps its TRANSPARENT parameter onto dlatch_mode_e.
package d_latch_pkg;

  localparam int DLATCH_DEFAULT_WIDTH = 1;

  typedef enum logic {
    DLATCH_REGISTERED  = 1'b0,
    DLATCH_TRANSPARENT = 1'b1
  } dlatch_mode_e;

  function automatic dlatch_mode_e dlatch_mode(input bit transparent);
    return transparent ? DLATCH_TRANSPARENT : DLATCH_REGISTERED;
  endfunction

endpackage

// File: rtl/d_latch_cell.sv
// One bit of latch storage: a flop with clock enable and synchronous reset.
// Reset wins over enable so a reset edge always lands on RESET_VALUE.
module d_latch_cell
  import d_latch_pkg::*;
#(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic q
);

  logic state;

  // NOTE: non-blocking assignment keeps every cell sampling pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RESET_VALUE;
    end else if (en) begin
      state <= d;
    end
  end

  assign q = state;

endmodule

// File: rtl/d_latch.sv
// Level-sensitive D latch emulated with flops, WIDTH independent bits.
// TRANSPARENT=1 adds a combinational bypass of d while enabled and out of reset.
module d_latch
  import d_latch_pkg::*;
#(
  parameter int              WIDTH       = DLATCH_DEFAULT_WIDTH,
  parameter bit              TRANSPARENT = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  input  logic             en
);

  localparam dlatch_mode_e MODE = dlatch_mode(TRANSPARENT);

  logic [WIDTH-1:0] state;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    d_latch_cell #(
      .RESET_VALUE (RESET_VALUE[i])
    ) u_cell (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .d   (d[i]),
      .q   (state[i])
    );
  end

  // NOTE: a continuous assign with both mux arms driven cannot infer a latch.
  if (MODE == DLATCH_TRANSPARENT) begin : g_transparent
    assign q = (en && !rst) ? d : state;
  end else begin : g_registered
    assign q = state;
  end

endmodule

// File: tb/tb_d_latch.sv
// Scoreboarded bench for d_latch: a 1-bit registered instance and an 8-bit
// transparent instance driven together, directed phases then random traffic.
module tb_d_latch;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       d1  = 1'b0;
  logic [7:0] d8  = 8'h00;
  logic       q1;
  logic [7:0] q8;

  always #5 clk = ~clk;

  d_latch #(.WIDTH(1), .TRANSPARENT(1'b0), .RESET_VALUE(1'b0)) u_reg (
    .clk (clk), .rst (rst), .q (q1), .d (d1), .en (en)
  );

  d_latch #(.WIDTH(8), .TRANSPARENT(1'b1), .RESET_VALUE(8'h00)) u_trn (
    .clk (clk), .rst (rst), .q (q8), .d (d8), .en (en)
  );

  typedef struct {
    bit         chk;
    logic       q1;
    logic [7:0] q8;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference: remembered value = the last d seen at an enabled edge since reset.
  bit         known = 0;
  logic       held1;
  logic [7:0] held8;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus right after an edge and queue what q must show.
  task automatic drive(input logic r, input logic e, input logic v1, input logic [7:0] v8);
    exp_t x;
    @(posedge clk);
    if (rst) begin
      known = 1;
      held1 = 1'b0;
      held8 = 8'h00;
    end else if (en) begin
      held1 = d1;
      held8 = d8;
    end
    #1;
    rst = r;
    en  = e;
    d1  = v1;
    d8  = v8;
    x.chk = known;
    x.q1  = held1;
    x.q8  = (e && !r) ? v8 : held8;
    sb.push_back(x);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        if (x.chk) begin
          check("q_registered", {7'b0, q1}, {7'b0, x.q1});
          check("q_transparent", q8, x.q8);
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not end, time %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    // Reset dominance
    drive(1, 1, 0, 8'h00);
    drive(1, 1, 1, 8'hFF);
    drive(1, 1, 1, 8'h5A);
    drive(1, 0, 1, 8'h77);
    // Hold while disabled
    drive(0, 0, 0, 8'h00);
    drive(0, 0, 1, 8'hFF);
    drive(0, 0, 0, 8'h11);
    // Latch high, then hold with d low
    drive(0, 0, 1, 8'hC3);
    drive(0, 1, 1, 8'hC3);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 8'h00);
    // Latch low, then hold with d high
    drive(0, 1, 0, 8'h0F);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 8'hF0);
    // Reset mid-hold
    drive(0, 1, 1, 8'h81);
    drive(0, 0, 0, 8'h00);
    drive(1, 0, 0, 8'h00);
    drive(0, 0, 1, 8'hEE);
    drive(0, 0, 1, 8'hEE);
    drive(0, 1, 1, 8'h42);
    drive(0, 0, 0, 8'h00);
    // Transparent-mode points
    drive(0, 1, 1, 8'hA5);
    drive(0, 0, 0, 8'h3C);
    drive(0, 0, 1, 8'h3C);
    drive(1, 1, 1, 8'hA5);
    drive(0, 0, 0, 8'h99);
    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 15) == 0), $urandom_range(0, 1),
            $urandom_range(0, 1), 8'($urandom));
    end
    drive(0, 0, 0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 8'(sb.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/d_latch.md
Name: d_latch

Overview:
- Synchronous emulation of a level-sensitive D latch with enable and reset, for use in FPGA/ASIC flows where true latches are disallowed.
- While enable is high, the stored value tracks the data input on every clock edge. While enable is low, the stored value holds.
- Reset clears the stored value to 0.
- Used as a generic holding/capture element in datapaths and for teaching-level storage blocks.

Parameters:
- WIDTH, 1, bit width of d and q.
- TRANSPARENT, 0:
  - 0: registered output (q updates one clock after the data change).
  - 1: q additionally passes d combinationally while en=1 and rst=0.
- RESET_VALUE, '0, value loaded into storage (and driven on q) by reset.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- q    output WIDTH  latched data output.
- d    input  WIDTH  data input.
- en   input  1  enable, active-high (latch "transparent" level).

Behaviour:
- One clock; reset is synchronous and active-high. It is sampled only at the rising edge of clk.
- Storage register `state` (WIDTH bits). At each rising clk edge:
  - rst=1: state <= RESET_VALUE. rst has priority over en and d.
  - rst=0, en=1: state <= d.
  - rst=0, en=0: state holds.
- Output with TRANSPARENT=0: q = state.
  - Latency from d to q with en=1 is 1 cycle.
  - After en falls, q keeps the d value sampled at the last edge where en=1.
- Output with TRANSPARENT=1:
  - q = (en && !rst) ? d : state.
  - Zero-latency pass-through while enabled; state still captures d each edge so the value holds when en falls.
- Reset output value: q = RESET_VALUE from the first edge with rst=1. It stays there for as long as rst=1, regardless of en and d.
- Reset mid-operation: a reset edge with en=1 and d=1 still yields q=0 (RESET_VALUE). The first edge after rst deasserts with en=1 loads d.
- Reset release with en=0: q remains RESET_VALUE until en is asserted.
- Changes on d while en=0 never affect q, in either mode.
- en falling and d changing in the same cycle: the edge at which en is sampled 0 holds. The value stored is the one captured at the last edge with en=1.
- No X propagation requirement beyond simulation: after power-up, state is undefined until the first reset edge.
- Bits are independent; the same rules apply per bit of WIDTH.

Decomposition:
- Package d_latch_pkg:
  - Default width constant DLATCH_DEFAULT_WIDTH = 1.
  - Mode enum dlatch_mode_e {DLATCH_REGISTERED, DLATCH_TRANSPARENT}, mapped to TRANSPARENT.
- One sub-module is natural: d_latch_cell.
  - A 1-bit clocked enable cell with sync reset, holding the per-bit state.
  - d_latch instantiates WIDTH copies in a generate loop and adds the TRANSPARENT output mux.

Test Plan:
1. Reset dominance: rst=1, en=1, d=0 then d=1 over 3 cycles -> q=0 on every cycle. Then en=0, still rst=1 -> q=0.
2. Hold when disabled: rst=0, en=0, toggle d 0->1->0 over 3 cycles -> q stays 0.
3. Latch high: en=0, d=1, then en=1 for one edge -> q=1 one cycle later (TRANSPARENT=0). Then en=0 and d=0 -> q remains 1 for ≥3 cycles.
4. Latch low: starting from q=1, d=0, en=1 for one edge -> q=0. Then en=0 and d=1 -> q remains 0.
5. Reset mid-hold: q=1 held with en=0, assert rst for one edge -> q=0. Release rst with en=0 -> q stays 0. Then en=1, d=1 -> q=1 next cycle.
6. Transparent mode (TRANSPARENT=1, WIDTH=8):
   - en=1, d=8'hA5 -> q=8'hA5 in the same cycle.
   - en=0, d=8'h3C -> q=8'hA5.
   - rst=1, en=1 -> q=8'h00.
